// File: rtl/fifo_stream_out.sv
// Read-side adapter for the synchronous FIFO: turns rd_en/data_out/empty into a
// valid/ready master stream through a 2-entry prefetch buffer, with flush and a transfer counter.
module fifo_stream_out #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_data,
    output logic               fifo_rd_en,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    input  logic               flush,
    output logic [1:0]         occupancy,
    output logic [COUNT_W-1:0] word_count
);

    logic             inflight;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop;
    logic             capture;
    logic             load_head;
    logic [2:0]       committed;

    assign m_valid = (occupancy != 2'd0);
    assign m_data  = head;

    // Slots already spoken for after this edge: buffered plus in-flight, minus the word leaving now.
    always_comb begin
        pop        = m_valid && m_ready;
        capture    = inflight && !flush;
        load_head  = capture && ((occupancy == 2'd0) || ((occupancy == 2'd1) && pop));
        committed  = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
        fifo_rd_en = rst_n && !fifo_empty && !flush && (committed < 3'd2);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy  <= 2'd0;
            inflight   <= 1'b0;
            word_count <= '0;
        end else if (flush) begin
            occupancy  <= 2'd0;
            inflight   <= 1'b0;
        end else begin
            occupancy  <= occupancy + {1'b0, capture} - {1'b0, pop};
            inflight   <= fifo_rd_en;
            if (pop) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

    // Head drives m_data directly, so it is reset to give a defined m_data=0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
        end else if (!flush) begin
            if (load_head) begin
                head <= fifo_data;
            end else if (pop && (occupancy == 2'd2)) begin
                head <= tail;
            end
        end
    end

    // NOTE: the tail slot is storage only and never observed while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture && !load_head) begin
            tail <= fifo_data;
        end
    end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Self-checking bench for fifo_stream_out: behavioural FIFO feeding the adapter,
// a cycle-table for directed sequences, and a queue scoreboard for random traffic.
module tb_fifo_stream_out;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;
    logic [15:0] word_count;

    logic        rd_en4;
    logic        valid4;
    logic [7:0]  data4;
    logic [1:0]  occ4;
    logic [3:0]  wc4;

    always #5 clk = ~clk;

    fifo_stream_out #(.WIDTH(8), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .flush(flush), .occupancy(occupancy), .word_count(word_count)
    );

    fifo_stream_out #(.WIDTH(8), .COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd_en4), .m_valid(valid4), .m_ready(m_ready), .m_data(data4),
        .flush(flush), .occupancy(occ4), .word_count(wc4)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural upstream FIFO: registered data_out one cycle after an accepted read.
    logic [7:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int reads = 0;
    int empty_reads = 0;

    always_comb fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 0;
            reads     <= 0;
            fifo_data <= 8'h00;
        end else if (fifo_rd_en) begin
            if (rd_ptr == wr_ptr) begin
                empty_reads <= empty_reads + 1;
            end else begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
                reads     <= reads + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    // Asserts reset asynchronously between edges, checks the reset state, then releases it.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_occ", occupancy, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_wc", word_count, 0);
        check("rst_wc4", wc4, 0);
        wr_ptr = 0;
        push(8'h5A);
        #1;
        check("rst_rd_en_forced", fifo_rd_en, 0);
        repeat (3) @(negedge clk);
        wr_ptr  = 0;
        m_ready = 1'b0;
        flush   = 1'b0;
        rst_n   = 1'b1;
    endtask

    typedef struct {
        logic        do_push;
        logic [7:0]  push_val;
        logic        rdy;
        logic        fl;
        logic        e_rd;
        logic        e_valid;
        logic [7:0]  e_data;
        logic [1:0]  e_occ;
        logic [15:0] e_wc;
    } vec_t;

    vec_t       vecs [20];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    logic [7:0] tmp;
    int         first_cyc;
    int         last_cyc;
    int         pushed;
    int         popped;
    logic       prev_stall;
    logic [7:0] prev_data;

    initial begin
        //           push  val    rdy  fl   rd   vld  data   occ  wc
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd0};
        vecs[1]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 2'd1, 16'd0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd1};
        vecs[5]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd1};
        vecs[6]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd1};
        vecs[7]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd1, 16'd1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2, 16'd1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 2'd2, 16'd1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 2'd1, 16'd1};
        vecs[13] = '{1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd2};
        vecs[14] = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd2};
        vecs[15] = '{1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB0, 2'd1, 16'd2};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 16'd2};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd2};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2, 2'd1, 16'd2};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd3};

        // Idle with an empty FIFO.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            check("idle_rd_en", fifo_rd_en, 0);
            check("idle_valid", m_valid, 0);
            check("idle_occ", occupancy, 0);
            check("idle_wc", word_count, 0);
        end

        // Cycle table: first-word latency, backpressure fill, flush at occupancy 2, flush with pop.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            m_ready = vecs[i].rdy;
            flush   = vecs[i].fl;
            if (vecs[i].do_push) push(vecs[i].push_val);
            #1;
            check($sformatf("vec%0d_rd_en", i), fifo_rd_en, vecs[i].e_rd);
            check($sformatf("vec%0d_valid", i), m_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) check($sformatf("vec%0d_data", i), m_data, vecs[i].e_data);
            check($sformatf("vec%0d_occ", i), occupancy, vecs[i].e_occ);
            check($sformatf("vec%0d_wc", i), word_count, vecs[i].e_wc);
        end
        flush = 1'b0;

        // 16 words at full throughput.
        do_reset();
        got.delete();
        first_cyc = -1;
        last_cyc  = -1;
        @(negedge clk);
        m_ready = 1'b1;
        for (int v = 0; v < 16; v++) push(8'(v));
        for (int c = 0; c < 60 && got.size() < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
            end
        end
        check("burst_count", got.size(), 16);
        for (int v = 0; v < got.size(); v++) check($sformatf("burst_word%0d", v), got[v], v);
        check("burst_first_latency", first_cyc, 2);
        check("burst_no_gap", last_cyc - first_cyc, 15);
        @(negedge clk);
        #1;
        check("burst_wc", word_count, 16);
        check("burst_valid_after", m_valid, 0);

        // Backpressure: 10 stalled cycles, then drain.
        do_reset();
        got.delete();
        @(negedge clk);
        m_ready = 1'b0;
        for (int v = 0; v < 16; v++) push(8'(v));
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (m_valid) check($sformatf("bp_hold_data%0d", c), m_data, 0);
        end
        check("bp_reads", reads, 2);
        check("bp_occ", occupancy, 2);
        check("bp_valid", m_valid, 1);
        check("bp_data", m_data, 0);
        for (int c = 0; c < 60 && got.size() < 16; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            if (m_valid && m_ready) got.push_back(m_data);
        end
        check("bp_count", got.size(), 16);
        for (int v = 0; v < got.size(); v++) check($sformatf("bp_word%0d", v), got[v], v);
        @(negedge clk);
        #1;
        check("bp_total_reads", reads, 16);
        check("bp_wc", word_count, 16);

        // Counter wrap on the narrow-counter instance.
        do_reset();
        @(negedge clk);
        m_ready = 1'b1;
        for (int v = 0; v < 17; v++) push(8'(v + 32));
        repeat (40) @(negedge clk);
        #1;
        check("wrap_wc4", wc4, 1);
        check("wrap_wc16", word_count, 17);
        check("wrap_valid4", valid4, 0);

        // Random traffic against a queue scoreboard.
        do_reset();
        exp_q.delete();
        pushed     = 0;
        popped     = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (int c = 0; c < 20000 && popped < 1000; c++) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                tmp = 8'($urandom_range(0, 255));
                push(tmp);
                exp_q.push_back(tmp);
                pushed++;
            end
            #1;
            if (prev_stall) begin
                check("rand_hold_valid", m_valid, 1);
                check("rand_hold_data", m_data, prev_data);
            end
            check("rand_occ_le2", occupancy <= 2'd2, 1);
            check("rand_valid_vs_occ", m_valid, occupancy != 2'd0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra_word", 1, 0);
                end else begin
                    tmp = exp_q.pop_front();
                    check("rand_word", m_data, tmp);
                end
                popped++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
        check("rand_popped", popped, 1000);
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        check("rand_wc", word_count, 1000);
        check("rand_wc4", wc4, 1000 % 16);

        // Reset asserted mid-burst with a full buffer.
        for (int v = 0; v < 4; v++) push(8'(v + 8'hC0));
        repeat (4) @(negedge clk);
        #1;
        check("midburst_occ_before", occupancy, 2);
        do_reset();

        check("no_read_when_empty", empty_reads, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
